// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared constants and types for the fetch front end.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OP_ITYPE  = 7'b0010011;
    localparam logic [6:0]  OP_RTYPE  = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_if
// Brief    : Word-addressed instruction-memory read port (combinational read).
// Revision : 1.0
// ============================================================================
interface if_stage_if #(
    parameter int AW = 8
) ();
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_instr;

    modport master (output imem_addr, input imem_instr);
    modport slave  (input imem_addr, output imem_instr);
endinterface
`default_nettype wire

// File: rtl/if_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module   : ifid_reg
// Brief    : IF/ID pipeline register; load, hold, otherwise insert a bubble.
// Revision : 1.0
// ============================================================================
module ifid_reg
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_load,
    input  wire logic            i_hold,
    input  wire logic [XLEN-1:0] i_pc,
    input  wire logic [31:0]     i_instr,
    input  wire logic            i_valid,
    output logic [XLEN-1:0]      o_pc,
    output logic [31:0]          o_instr,
    output logic                 o_valid
);

    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (rst || (!i_load && !i_hold)) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= i_valid;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch: PC, run/halt FSM, fetch counter and IF/ID register.
// Revision : 1.0
// ============================================================================
module if_stage
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     IMEM_DEPTH = 256
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    input  wire logic            start_i,
    input  wire logic            stall_i,
    input  wire logic            flush_i,
    input  wire logic [XLEN-1:0] redirect_pc_i,
    if_stage_if.master           imem,
    output logic [XLEN-1:0]      pc_o,
    output logic [XLEN-1:0]      ifid_pc_o,
    output logic [31:0]          ifid_instr_o,
    output logic                 ifid_valid_o,
    output logic [6:0]           op_o,
    output logic                 running_o,
    output logic                 halted_o,
    output logic [31:0]          fetch_count_o
);

    localparam int unsigned     AW      = $clog2(IMEM_DEPTH);
    localparam logic [XLEN-1:0] c_DEPTH = XLEN'(IMEM_DEPTH);

    fetch_state_t    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt, w_redirect;
    logic [31:0]     r_fetch_count;
    logic            w_oor, w_count_inc;
    logic            w_ifid_load, w_ifid_hold, w_ifid_valid;
    logic [31:0]     w_ifid_instr;

    assign w_redirect = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign w_oor      = {2'b00, r_pc[XLEN-1:2]} >= c_DEPTH;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_count_inc && (r_fetch_count != 32'hFFFF_FFFF))
                r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // IF/ID defaults to a bubble; only RUN loads or holds it.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_count_inc  = 1'b0;
        w_ifid_load  = 1'b0;
        w_ifid_hold  = 1'b0;
        w_ifid_instr = NOP_INSTR;
        w_ifid_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush_i) w_pc_nxt = w_redirect;
                if (start_i) w_state_nxt = RUN;
            end
            RUN: begin
                if (flush_i) begin
                    w_pc_nxt = w_redirect;
                end else if (stall_i) begin
                    w_ifid_hold = 1'b1;
                end else if (w_oor) begin
                    w_ifid_load = 1'b1;
                    w_state_nxt = HALT;
                end else begin
                    w_ifid_load  = 1'b1;
                    w_ifid_instr = imem.imem_instr;
                    w_ifid_valid = 1'b1;
                    w_pc_nxt     = r_pc + XLEN'(4);
                    w_count_inc  = 1'b1;
                end
            end
            HALT: begin
                if (flush_i) begin
                    w_pc_nxt    = w_redirect;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    ifid_reg #(.XLEN(XLEN)) u_ifid (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_load  (w_ifid_load),
        .i_hold  (w_ifid_hold),
        .i_pc    (r_pc),
        .i_instr (w_ifid_instr),
        .i_valid (w_ifid_valid),
        .o_pc    (ifid_pc_o),
        .o_instr (ifid_instr_o),
        .o_valid (ifid_valid_o)
    );

    assign imem.imem_addr = r_pc[AW+1:2];
    assign pc_o           = r_pc;
    assign op_o           = ifid_valid_o ? ifid_instr_o[6:0] : OP_ITYPE;
    assign running_o      = (r_state == RUN);
    assign halted_o       = (r_state == HALT);
    assign fetch_count_o  = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Directed bench: DUT A (256 words), B (4 words), C (top-of-space PC).
// Revision : 1.0
// ============================================================================
module tb_if_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] redir = '0;
    logic [31:0] mem [0:255];
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    if_stage_if #(.AW(8))  a_if ();
    if_stage_if #(.AW(2))  b_if ();
    if_stage_if #(.AW(30)) c_if ();

    assign a_if.imem_instr = mem[a_if.imem_addr];
    assign b_if.imem_instr = mem[{6'b0, b_if.imem_addr}];
    assign c_if.imem_instr = 32'h0010_8133;

    logic [31:0] a_pc, a_ipc, a_iins, a_cnt, b_pc, b_ipc, b_iins, b_cnt, c_pc, c_ipc, c_iins, c_cnt;
    logic [6:0]  a_op, b_op, c_op;
    logic        a_v, a_run, a_halt, b_v, b_run, b_halt, c_v, c_run, c_halt;

    if_stage #(.XLEN(32), .RESET_PC(32'h0), .IMEM_DEPTH(256)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
        .redirect_pc_i(redir), .imem(a_if), .pc_o(a_pc), .ifid_pc_o(a_ipc),
        .ifid_instr_o(a_iins), .ifid_valid_o(a_v), .op_o(a_op), .running_o(a_run),
        .halted_o(a_halt), .fetch_count_o(a_cnt));

    if_stage #(.XLEN(32), .RESET_PC(32'h0), .IMEM_DEPTH(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
        .redirect_pc_i(redir), .imem(b_if), .pc_o(b_pc), .ifid_pc_o(b_ipc),
        .ifid_instr_o(b_iins), .ifid_valid_o(b_v), .op_o(b_op), .running_o(b_run),
        .halted_o(b_halt), .fetch_count_o(b_cnt));

    if_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .IMEM_DEPTH(1 << 30)) dut_c (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
        .redirect_pc_i(redir), .imem(c_if), .pc_o(c_pc), .ifid_pc_o(c_ipc),
        .ifid_instr_o(c_iins), .ifid_valid_o(c_v), .op_o(c_op), .running_o(c_run),
        .halted_o(c_halt), .fetch_count_o(c_cnt));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_start();
        rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (a_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", a_pc, 32'h0); end
        checks++; if (a_ipc !== 32'h0 || a_iins !== 32'h13 || a_v !== 1'b0) begin errors++;
            $display("FAIL reset_ifid got=%h/%h/%b exp=0/13/0", a_ipc, a_iins, a_v); end
        checks++; if (a_op !== 7'h13 || a_cnt !== 32'h0) begin errors++;
            $display("FAIL reset_op_cnt got=%h/%0d exp=13/0", a_op, a_cnt); end
        checks++; if (a_run !== 1'b0 || a_halt !== 1'b0) begin errors++;
            $display("FAIL reset_state got run=%b halt=%b exp 0/0", a_run, a_halt); end
        checks++; if (c_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_c got=%h exp=fffffffc", c_pc); end
    endtask

    task automatic test_fetch();
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (a_run !== 1'b1 || a_pc !== 32'h0 || a_cnt !== 32'h0) begin errors++;
            $display("FAIL start got run=%b pc=%h cnt=%0d exp 1/0/0", a_run, a_pc, a_cnt); end
        tick();
        checks++; if (a_ipc !== 32'h0 || a_iins !== 32'h0010_0093 || a_op !== 7'h13 || a_v !== 1'b1) begin errors++;
            $display("FAIL fetch0 got pc=%h ins=%h op=%h v=%b exp 0/00100093/13/1", a_ipc, a_iins, a_op, a_v); end
        tick();
        checks++; if (a_ipc !== 32'h4 || a_op !== 7'h33) begin errors++;
            $display("FAIL fetch1 got pc=%h op=%h exp 4/33", a_ipc, a_op); end
        tick();
        checks++; if (a_ipc !== 32'h8 || a_op !== 7'h13 || a_cnt !== 32'd3 || a_pc !== 32'hC) begin errors++;
            $display("FAIL fetch2 got ipc=%h op=%h cnt=%0d pc=%h exp 8/13/3/c", a_ipc, a_op, a_cnt, a_pc); end
        checks++; if (a_if.imem_addr !== 8'd3) begin errors++; $display("FAIL imem_addr got=%0d exp=3", a_if.imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (a_pc !== 32'hC || a_ipc !== 32'h8 || a_iins !== 32'h0050_0193 || a_v !== 1'b1 || a_cnt !== 32'd3) begin
                errors++;
                $display("FAIL stall%0d got pc=%h ipc=%h ins=%h v=%b cnt=%0d exp c/8/00500193/1/3",
                         i, a_pc, a_ipc, a_iins, a_v, a_cnt);
            end
        end
        stall = 1'b0;
        tick();
        checks++; if (a_ipc !== 32'hC || a_op !== 7'h33 || a_cnt !== 32'd4 || a_pc !== 32'h10) begin errors++;
            $display("FAIL stall_resume got ipc=%h op=%h cnt=%0d pc=%h exp c/33/4/10", a_ipc, a_op, a_cnt, a_pc); end
    endtask

    task automatic test_flush_over_stall();
        flush = 1'b1; stall = 1'b1; redir = 32'h0000_0023;
        tick();
        flush = 1'b0; stall = 1'b0;
        checks++; if (a_pc !== 32'h20 || a_v !== 1'b0 || a_op !== 7'h13 || a_ipc !== 32'h0 || a_cnt !== 32'd4) begin errors++;
            $display("FAIL flush got pc=%h v=%b op=%h ipc=%h cnt=%0d exp 20/0/13/0/4", a_pc, a_v, a_op, a_ipc, a_cnt); end
        tick();
        checks++; if (a_ipc !== 32'h20 || a_iins !== 32'h0080_0013 || a_v !== 1'b1 || a_cnt !== 32'd5 || a_pc !== 32'h24) begin errors++;
            $display("FAIL flush_fetch got ipc=%h ins=%h v=%b cnt=%0d pc=%h exp 20/00800013/1/5/24", a_ipc, a_iins, a_v, a_cnt, a_pc); end
    endtask

    task automatic test_out_of_range();
        do_reset_start();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (b_pc !== 32'h10 || b_cnt !== 32'd4 || b_run !== 1'b1) begin errors++;
            $display("FAIL oor_pre got pc=%h cnt=%0d run=%b exp 10/4/1", b_pc, b_cnt, b_run); end
        tick();
        checks++; if (b_halt !== 1'b1 || b_run !== 1'b0 || b_pc !== 32'h10 || b_v !== 1'b0 || b_ipc !== 32'h10 || b_op !== 7'h13) begin
            errors++;
            $display("FAIL oor_halt got halt=%b run=%b pc=%h v=%b ipc=%h op=%h exp 1/0/10/0/10/13",
                     b_halt, b_run, b_pc, b_v, b_ipc, b_op);
        end
        tick();
        checks++; if (b_halt !== 1'b1 || b_pc !== 32'h10 || b_cnt !== 32'd4 || b_v !== 1'b0) begin errors++;
            $display("FAIL oor_hold got halt=%b pc=%h cnt=%0d v=%b exp 1/10/4/0", b_halt, b_pc, b_cnt, b_v); end
        flush = 1'b1; redir = 32'h0;
        tick();
        flush = 1'b0;
        checks++; if (b_run !== 1'b1 || b_halt !== 1'b0 || b_pc !== 32'h0 || b_v !== 1'b0) begin errors++;
            $display("FAIL oor_flush got run=%b halt=%b pc=%h v=%b exp 1/0/0/0", b_run, b_halt, b_pc, b_v); end
        tick();
        checks++; if (b_ipc !== 32'h0 || b_v !== 1'b1 || b_cnt !== 32'd5) begin errors++;
            $display("FAIL oor_refetch got ipc=%h v=%b cnt=%0d exp 0/1/5", b_ipc, b_v, b_cnt); end
    endtask

    task automatic test_reset_in_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (a_run !== 1'b1 || a_halt !== 1'b0) begin errors++;
            $display("FAIL start_in_run got run=%b halt=%b exp 1/0", a_run, a_halt); end
        stall = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        checks++; if (a_pc !== 32'h0 || a_ipc !== 32'h0 || a_iins !== 32'h13 || a_v !== 1'b0 || a_op !== 7'h13 ||
                      a_cnt !== 32'h0 || a_run !== 1'b0 || a_halt !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_run got pc=%h ipc=%h ins=%h v=%b op=%h cnt=%0d run=%b halt=%b",
                     a_pc, a_ipc, a_iins, a_v, a_op, a_cnt, a_run, a_halt);
        end
        tick();
        checks++; if (a_pc !== 32'h0 || a_cnt !== 32'h0 || a_run !== 1'b0 || a_v !== 1'b0) begin errors++;
            $display("FAIL idle_hold got pc=%h cnt=%0d run=%b v=%b exp 0/0/0/0", a_pc, a_cnt, a_run, a_v); end
        flush = 1'b1; redir = 32'h0000_0042;
        tick();
        flush = 1'b0;
        checks++; if (a_pc !== 32'h40 || a_run !== 1'b0 || a_v !== 1'b0) begin errors++;
            $display("FAIL idle_flush got pc=%h run=%b v=%b exp 40/0/0", a_pc, a_run, a_v); end
    endtask

    task automatic test_wrap();
        do_reset_start();
        checks++; if (c_pc !== 32'hFFFF_FFFC || c_run !== 1'b1) begin errors++;
            $display("FAIL wrap_start got pc=%h run=%b exp fffffffc/1", c_pc, c_run); end
        tick();
        checks++; if (c_pc !== 32'h0 || c_ipc !== 32'hFFFF_FFFC || c_v !== 1'b1 || c_op !== 7'h33 || c_cnt !== 32'd1) begin errors++;
            $display("FAIL wrap got pc=%h ipc=%h v=%b op=%h cnt=%0d exp 0/fffffffc/1/33/1", c_pc, c_ipc, c_v, c_op, c_cnt); end
        flush = 1'b1; redir = 32'hFFFF_FFFF;
        tick();
        flush = 1'b0;
        checks++; if (c_pc !== 32'hFFFF_FFFC || c_v !== 1'b0 || c_cnt !== 32'd1) begin errors++;
            $display("FAIL wrap_flush got pc=%h v=%b cnt=%0d exp fffffffc/0/1", c_pc, c_v, c_cnt); end
        tick();
        checks++; if (c_pc !== 32'h0 || c_ipc !== 32'hFFFF_FFFC || c_cnt !== 32'd2) begin errors++;
            $display("FAIL wrap_again got pc=%h ipc=%h cnt=%0d exp 0/fffffffc/2", c_pc, c_ipc, c_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
        mem[0] = 32'h0010_0093;
        mem[1] = 32'h0010_8133;
        mem[2] = 32'h0050_0193;
        mem[3] = 32'h0020_81B3;
        test_reset();
        test_fetch();
        test_stall();
        test_flush_over_stall();
        test_out_of_range();
        test_reset_in_run();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
